mem_access_unit: RTL and testbench

Load/store initiator driving the word-addressed `Memory` port (`ren`, `wen`, `addr`, `din`, `dout`) on behalf of the multicycle MIPS datapath. It accepts byte-addressed byte, half and word requests and converts them to word accesses. Loads get lane extraction with sign or zero extension. Sub-word stores become a read-modify-write sequence. Misaligned and out-of-range requests are rejected without touching memory.

---
 rtl/mem_access_unit_pkg.sv | 36 +++
 rtl/mem_access_unit_lane_align.sv | 39 +++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, state encoding and request screening for the load/store unit.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  localparam int MEM_WORDS  = 1024;
  localparam int ADDR_BITS  = $clog2(MEM_WORDS) + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP,
    ST_ERR
  } state_t;

  // A request is rejected for an illegal size, misalignment, or a byte
  // address outside the 4 KB window.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = (addr[31:ADDR_BITS] != '0);
    case (size)
      SZ_HALF: bad = bad | addr[0];
      SZ_WORD: bad = bad | (|addr[1:0]);
      SZ_BAD:  bad = 1'b1;
      default: bad = bad;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane extraction/extension for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output gets a default at the top so no path through the case infers a latch.
  always_comb begin
    byte_lane = word[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    load_val  = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{is_signed & byte_lane[7]}}, byte_lane};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{is_signed & half_lane[15]}}, half_lane};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: turns byte-addressed byte/half/word requests into word
// accesses on a single-port memory, with read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;

  logic [31:0] align_word, load_val, merged;

  // The aligner sees live memory data while reading and the held word while merging.
  assign align_word = (state_q == ST_RMW_WR) ? word_q : mem_dout;

  mem_lane_align u_align (
    .word      (align_word),
    .addr_lo   (lane_q),
    .size      (size_q),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .load_val  (load_val),
    .merged    (merged)
  );

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    din_d    = din_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lane_d   = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          if (req_is_bad(req_size, req_addr)) begin
            state_d = ST_ERR;
          end else begin
            addr_d = {2'b00, req_addr[31:2]};
            if (!req_we) begin
              state_d = ST_RD;
            end else if (req_size == SZ_WORD) begin
              din_d   = req_wdata;
              state_d = ST_WR;
            end else begin
              state_d = ST_RMW_RD;
            end
          end
        end
      end
      ST_RD: begin
        rdata_d = load_val;
        state_d = ST_RESP;
      end
      ST_WR:     state_d = ST_RESP;
      ST_RMW_RD: begin
        word_d  = mem_dout;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        din_d   = merged;
        state_d = ST_RESP;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  // Strobes decode the state register alone, so read and write can never overlap.
  assign req_ready = (state_q == ST_IDLE);
  assign mem_ren   = (state_q == ST_RD) || (state_q == ST_RMW_RD);
  assign mem_wen   = (state_q == ST_WR) || (state_q == ST_RMW_WR);
  assign rsp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign rsp_err   = (state_q == ST_ERR);
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_din   = (state_q == ST_RMW_WR) ? merged : din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a falling-edge-write memory model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_din, mem_dout;

  int checks = 0;
  int failures = 0;
  int overlap_cnt = 0;
  int ready_bad = 0;

  logic [31:0] mem [0:1023];

  mem_access_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  // Memory: combinational read, write on the falling edge only while out of reset.
  assign mem_dout = mem[mem_addr[9:0]];
  always @(negedge clock) begin
    if (reset && mem_wen) mem[mem_addr[9:0]] <= mem_din;
  end

  always @(negedge clock) begin
    if (mem_ren && mem_wen) overlap_cnt++;
    if (req_ready && (rsp_valid || mem_ren || mem_wen)) ready_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          ren;
    int          wen;
    logic [31:0] din;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input int lat,
                              input int ren, input int wen, input logic [31:0] din);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.lat = lat; v.ren = ren; v.wen = wen; v.din = din;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one request and watch up to six cycles after acceptance; cycle c is
  // observed at the falling edge before rising edge c.
  task automatic run_req(input string name, input vec_t v);
    int lat = 0, ren_cnt = 0, wen_cnt = 0, wen_c = 0;
    logic err = 1'b0;
    logic [31:0] rdata = '0, ren_addr = '0, wen_addr = '0, wen_din = '0;
    wait_ready(name);
    req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (c == 1) req_valid = 1'b0;
      if (mem_ren) begin ren_cnt++; ren_addr = mem_addr; end
      if (mem_wen) begin wen_cnt++; wen_c = c; wen_addr = mem_addr; wen_din = mem_din; end
      if (rsp_valid) begin lat = c; err = rsp_err; rdata = rsp_rdata; break; end
    end
    check({name, "_lat"}, lat, v.lat);
    check({name, "_err"}, {31'd0, err}, {31'd0, v.err});
    check({name, "_rdata"}, rdata, v.rdata);
    check({name, "_ren_cnt"}, ren_cnt, v.ren);
    check({name, "_wen_cnt"}, wen_cnt, v.wen);
    if (v.ren != 0) check({name, "_ren_addr"}, ren_addr, {2'b00, v.addr[31:2]});
    if (v.wen != 0) begin
      check({name, "_wen_addr"}, wen_addr, {2'b00, v.addr[31:2]});
      check({name, "_din"}, wen_din, v.din);
      check({name, "_wen_cycle"}, wen_c, v.lat - 1);
    end
  endtask

  function automatic logic [31:0] stream_data(input int p);
    return 32'hA500_0000 | (p * 32'h0001_0203);
  endfunction

  vec_t vecs[$];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  initial begin
    // Word 4 (byte 0x10) is first written through the unit, then probed.
    vecs.push_back(mk(1, 2'd2, 0, 32'h10, 32'h8899AABB, 0, 32'h0, 2, 0, 1, 32'h8899AABB));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h8899AABB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h13, 32'h0, 0, 32'hFFFFFF88, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h13, 32'h0, 0, 32'h00000088, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h12, 32'h0, 0, 32'hFFFF8899, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'd1, 0, 32'h10, 32'h0, 0, 32'h0000AABB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h10, 32'h0, 0, 32'hFFFFFFBB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h10, 32'h0, 0, 32'hFFFFAABB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h11, 32'h0, 0, 32'h000000AA, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 32'h11, 32'h123456CC, 0, 32'h0, 3, 1, 1, 32'h8899CCBB));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h8899CCBB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h12, 32'hDEAD1234, 0, 32'h0, 3, 1, 1, 32'h1234CCBB));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h1234CCBB, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 32'h13, 32'h00000077, 0, 32'h0, 3, 1, 1, 32'h7734CCBB));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h7734CCBB, 2, 1, 0, 32'h0));
    // Rejections: no memory strobe, error at +1.
    vecs.push_back(mk(0, 2'd2, 0, 32'h12, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h11, 32'hFFFF, 1, 32'h0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h1000, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h11, 32'h55555555, 1, 32'h0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 32'hFFFFFFF0, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h7734CCBB, 2, 1, 0, 32'h0));
    // Last word of the window is legal.
    vecs.push_back(mk(1, 2'd2, 0, 32'hFFC, 32'hCAFEF00D, 0, 32'h0, 2, 0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 2'd1, 0, 32'hFFE, 32'h0, 0, 32'h0000CAFE, 2, 1, 0, 32'h0));

    // Reset state.
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_ren", {31'd0, mem_ren}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_req($sformatf("v%0d", i), vecs[i]);

    // Reset during RMW_WR drops the write and the response.
    run_req("restore", mk(1, 2'd2, 0, 32'h10, 32'h8899AABB, 0, 32'h0, 2, 0, 1, 32'h8899AABB));
    begin
      int rv_seen = 0;
      int strobe_seen = 0;
      wait_ready("rr");
      req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h11; req_wdata = 32'hCC; req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      check("rr_ren_c1", {31'd0, mem_ren}, 32'd1);
      @(posedge clock);
      #1;
      check("rr_wen_c2", {31'd0, mem_wen}, 32'd1);
      check("rr_din_c2", mem_din, 32'h8899CCBB);
      reset = 1'b0;
      #1;
      check("rr_wen_drop", {31'd0, mem_wen}, 32'd0);
      check("rr_ready_now", {31'd0, req_ready}, 32'd1);
      check("rr_din_clr", mem_din, 32'd0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        if (rsp_valid) rv_seen++;
        if (mem_ren || mem_wen) strobe_seen++;
      end
      #2 reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        if (rsp_valid) rv_seen++;
      end
      check("rr_no_rsp", rv_seen, 0);
      check("rr_no_strobe", strobe_seen, 0);
    end
    run_req("rr_after", mk(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h8899AABB, 2, 1, 0, 32'h0));

    // Back-to-back stream: store word then load it back, req_valid held high.
    begin
      int idx = 0;
      int accepts = 0;
      int resps = 0;
      bit advance = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
      wait_ready("st");
      req_size = 2'd2; req_signed = 1'b0;
      req_we = 1'b1; req_addr = 32'h200; req_wdata = stream_data(0);
      req_valid = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (cyc != 0) @(negedge clock);
        if (advance) begin
          check("st_busy_after_accept", {31'd0, req_ready}, 32'd0);
          idx++;
          req_we    = (idx % 2 == 0);
          req_addr  = 32'h200 + ((idx / 2) % 16) * 4;
          req_wdata = stream_data(idx / 2);
          advance   = 1'b0;
        end
        if (rsp_valid) begin
          resps++;
          if (exp_q.size() == 0) begin
            check("st_unexpected_rsp", 32'd1, 32'd0);
          end else begin
            check($sformatf("st_rdata%0d", resps), rsp_rdata, exp_q.pop_front());
            check($sformatf("st_err%0d", resps), {31'd0, rsp_err}, {31'd0, exp_err_q.pop_front()});
          end
        end
        if (req_ready) begin
          exp_q.push_back(req_we ? 32'h0 : stream_data(idx / 2));
          exp_err_q.push_back(1'b0);
          accepts++;
          advance = 1'b1;
        end
      end
      @(posedge clock);
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        req_valid = 1'b0;
        if (rsp_valid) begin
          resps++;
          if (exp_q.size() == 0) begin
            check("st_unexpected_rsp", 32'd1, 32'd0);
          end else begin
            check($sformatf("st_rdata%0d", resps), rsp_rdata, exp_q.pop_front());
            check($sformatf("st_err%0d", resps), {31'd0, rsp_err}, {31'd0, exp_err_q.pop_front()});
          end
        end
      end
      check("st_accepts_min", {31'd0, (accepts >= 60)}, 32'd1);
      check("st_all_answered", resps, accepts);
      check("st_queue_empty", exp_q.size(), 0);
    end

    check("no_ren_wen_overlap", overlap_cnt, 0);
    check("ready_only_idle", ready_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
